// File: rtl/waveform_pkg.sv
// -----------------------------------------------------------------------------
// waveform_pkg
//
// Shared types and constants for the waveform generator's frequency-hop
// sequencer.
//
//   CTRL_W      : width of the signed phase-step control word
//   DWELL_W     : width of the per-entry dwell count (clk cycles)
//   hop_entry_t : one table entry, {signed control, unsigned dwell}
//   hop_state_t : sequencer FSM state, IDLE or RUN
//   dwell_load  : dwell value actually loaded into the counter (0 -> 1)
// -----------------------------------------------------------------------------
package waveform_pkg;

  localparam int CTRL_W  = 9;
  localparam int DWELL_W = 16;

  typedef struct packed {
    logic signed [CTRL_W-1:0] control;
    logic        [DWELL_W-1:0] dwell;
  } hop_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } hop_state_t;

  // A dwell of zero still has to present the entry for one cycle, so the
  // counter never starts at zero.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/waveform_hop_table.sv
// -----------------------------------------------------------------------------
// waveform_hop_table
//
// DEPTH-entry register file of hop_entry_t with an asynchronous clear, one
// synchronous write port and one combinational read port.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high clear of every entry to zero
//   we       in   write enable (caller gates it with its own busy flag)
//   wr_addr  in   write address
//   wr_entry in   entry to store
//   rd_addr  in   read address
//   rd_entry out  entry at rd_addr (combinational)
// -----------------------------------------------------------------------------
module waveform_hop_table
  import waveform_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  hop_entry_t               wr_entry,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output hop_entry_t               rd_entry
);

  hop_entry_t mem [DEPTH];

  // DEPTH is a power of two, so every address value names a real entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/waveform_hop_scheduler.sv
// -----------------------------------------------------------------------------
// waveform_hop_scheduler
//
// Frequency-hop sequencer. Steps through a programmable table of
// (control, dwell) entries and drives the waveform generator's signed
// phase-step control word for each entry's dwell time. Sequences are
// one-shot or looping.
//
// Parameters:
//   DEPTH   : number of table entries (power of two, 2..16)
//   CTRL_W  : control word width; must equal waveform_pkg::CTRL_W
//   DWELL_W : dwell counter width; must equal waveform_pkg::DWELL_W
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   reset       in   asynchronous active-high reset (also clears the table)
//   cfg_we      in   table write strobe, honoured only while idle
//   cfg_addr    in   table write address
//   cfg_control in   signed control value for the entry
//   cfg_dwell   in   dwell cycles for the entry (0 behaves as 1)
//   num_steps   in   sequence length, sampled at start
//   loop_en     in   wrap to entry 0 after the last step, sampled at start
//   start       in   single-cycle start pulse
//   stop        in   single-cycle abort pulse
//   control     out  registered control word to the waveform generator
//   busy        out  high while a sequence runs
//   step_idx    out  index of the entry currently applied
//   step_strobe out  pulse in the first cycle of each newly applied entry
//   done        out  pulse on natural completion of a non-looping sequence
//   cfg_err     out  pulse when start is rejected for a bad num_steps
//
// Handshake: start and stop are single-cycle pulses with no ready; start is
// acted on only in IDLE and only when stop is low in the same cycle, stop is
// acted on only in RUN and takes priority over a dwell expiry in that cycle.
// Every output is a register, so nothing on the input side reaches an output
// within the same cycle.
// -----------------------------------------------------------------------------
module waveform_hop_scheduler
  import waveform_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CTRL_W  = waveform_pkg::CTRL_W,
  parameter int DWELL_W = waveform_pkg::DWELL_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic signed [CTRL_W-1:0]   cfg_control,
  input  logic [DWELL_W-1:0]         cfg_dwell,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       loop_en,
  input  logic                       start,
  input  logic                       stop,
  output logic signed [CTRL_W-1:0]   control,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       step_strobe,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MAX_STEPS = (AW+1)'(DEPTH);

  hop_state_t          state;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [AW-1:0]       last_idx;   // latched num_steps-1
  logic                loop_q;     // latched loop_en

  hop_entry_t          wr_entry;
  hop_entry_t          rd_entry;
  logic [AW-1:0]       rd_addr;
  logic                table_we;

  logic                num_ok;
  logic                at_last;
  logic                dwell_end;

  // ---------------------------------------------------------------------------
  // Entry table; frozen while a sequence runs.
  // ---------------------------------------------------------------------------
  assign table_we = cfg_we & ~busy;
  assign wr_entry = '{control: cfg_control, dwell: cfg_dwell};

  waveform_hop_table #(
    .DEPTH (DEPTH)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (table_we),
    .wr_addr  (cfg_addr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_addr),
    .rd_entry (rd_entry)
  );

  // ---------------------------------------------------------------------------
  // Next-entry selection. The read port always looks at the entry that would
  // be applied at the next load: entry 0 when idle (start) or after the last
  // step (wrap), otherwise the following entry.
  // ---------------------------------------------------------------------------
  assign num_ok    = (num_steps != '0) && (num_steps <= MAX_STEPS);
  assign at_last   = (step_idx == last_idx);
  assign dwell_end = (dwell_cnt == DWELL_W'(1));

  always_comb begin
    rd_addr = '0;
    if (state == RUN && !at_last) begin
      rd_addr = step_idx + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, dwell counter and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dwell_cnt   <= '0;
      last_idx    <= '0;
      loop_q      <= 1'b0;
      control     <= '0;
      busy        <= 1'b0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only on their event.
      step_strobe <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;

      case (state)
        IDLE: begin
          // stop in the same cycle suppresses start entirely, including the
          // num_steps range check.
          if (start && !stop) begin
            if (num_ok) begin
              state       <= RUN;
              busy        <= 1'b1;
              step_idx    <= '0;
              control     <= rd_entry.control;
              step_strobe <= 1'b1;
              dwell_cnt   <= dwell_load(rd_entry.dwell);
              // For num_steps == DEPTH the low bits are zero and the
              // subtraction wraps to DEPTH-1, which is the wanted last index.
              last_idx    <= num_steps[AW-1:0] - AW'(1);
              loop_q      <= loop_en;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        RUN: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            control   <= '0;
            step_idx  <= '0;
            dwell_cnt <= '0;
          end else if (dwell_end) begin
            if (!at_last || loop_q) begin
              // rd_addr already holds idx+1 or the wrap to 0.
              step_idx    <= rd_addr;
              control     <= rd_entry.control;
              step_strobe <= 1'b1;
              dwell_cnt   <= dwell_load(rd_entry.dwell);
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              control   <= '0;
              step_idx  <= '0;
              dwell_cnt <= '0;
              done      <= 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_hop_scheduler.sv
// -----------------------------------------------------------------------------
// tb_waveform_hop_scheduler
//
// Directed bench for waveform_hop_scheduler. Inputs change 1 time unit after
// a rising edge and outputs are sampled at the same point, so "k" below is the
// number of rising edges since the edge that accepted start (k=1 is the first
// cycle the new entry is on the output).
// -----------------------------------------------------------------------------
module tb_waveform_hop_scheduler;

  localparam int DEPTH   = 8;
  localparam int CTRL_W  = 9;
  localparam int DWELL_W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                      cfg_we      = 1'b0;
  logic [2:0]                cfg_addr    = '0;
  logic signed [CTRL_W-1:0]  cfg_control = '0;
  logic [DWELL_W-1:0]        cfg_dwell   = '0;
  logic [3:0]                num_steps   = '0;
  logic                      loop_en     = 1'b0;
  logic                      start       = 1'b0;
  logic                      stop        = 1'b0;
  logic signed [CTRL_W-1:0]  control;
  logic                      busy;
  logic [2:0]                step_idx;
  logic                      step_strobe;
  logic                      done;
  logic                      cfg_err;

  waveform_hop_scheduler #(
    .DEPTH   (DEPTH),
    .CTRL_W  (CTRL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_control (cfg_control),
    .cfg_dwell   (cfg_dwell),
    .num_steps   (num_steps),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .control     (control),
    .busy        (busy),
    .step_idx    (step_idx),
    .step_strobe (step_strobe),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Comparison and driver tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int ctrl, input int dwell);
    cfg_addr    = 3'(addr);
    cfg_control = CTRL_W'(ctrl);
    cfg_dwell   = DWELL_W'(dwell);
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic pulse_start(input int ns, input logic le);
    num_steps = 4'(ns);
    loop_en   = le;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " control"}, control, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " step_idx"}, step_idx, 0);
    chk({tag, " step_strobe"}, step_strobe, 0);
    chk({tag, " done"}, done, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Expected one-pass profile of table {8,40},{-3,100},{1,250}
  // ---------------------------------------------------------------------------
  function automatic int exp_ctrl(input int k);
    if (k <= 40)  return 8;
    if (k <= 140) return -3;
    if (k <= 390) return 1;
    return 0;
  endfunction

  function automatic int exp_idx(input int k);
    if (k <= 40)  return 0;
    if (k <= 140) return 1;
    if (k <= 390) return 2;
    return 0;
  endfunction

  function automatic int exp_strobe(input int k);
    return (k == 1 || k == 41 || k == 141) ? 1 : 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    #1;
    chk("reset async control", control, 0);
    tick();
    tick();
    chk_idle("reset");
    chk("reset cfg_err", cfg_err, 0);
    reset = 1'b0;
    tick();

    // Program the three-entry table
    wr(0, 8, 40);
    wr(1, -3, 100);
    wr(2, 1, 250);

    // One-shot sequence
    pulse_start(3, 1'b0);
    for (int k = 1; k <= 392; k++) begin
      chk($sformatf("oneshot control k=%0d", k), control, exp_ctrl(k));
      chk($sformatf("oneshot strobe k=%0d", k), step_strobe, exp_strobe(k));
      chk($sformatf("oneshot idx k=%0d", k), step_idx, exp_idx(k));
      chk($sformatf("oneshot busy k=%0d", k), busy, (k <= 390) ? 1 : 0);
      chk($sformatf("oneshot done k=%0d", k), done, (k == 391) ? 1 : 0);
      tick();
    end

    // Looping sequence, 800 cycles, period 390
    pulse_start(3, 1'b1);
    for (int k = 1; k <= 800; k++) begin
      int kk;
      kk = ((k - 1) % 390) + 1;
      chk($sformatf("loop control k=%0d", k), control, exp_ctrl(kk));
      chk($sformatf("loop strobe k=%0d", k), step_strobe, exp_strobe(kk));
      chk($sformatf("loop idx k=%0d", k), step_idx, exp_idx(kk));
      chk($sformatf("loop done k=%0d", k), done, 0);
      chk($sformatf("loop busy k=%0d", k), busy, 1);
      tick();
    end
    pulse_stop();
    chk_idle("loop stop");

    // stop coincident with a step boundary (k=40 is the last cycle of entry 0)
    pulse_start(3, 1'b1);
    repeat (39) tick();
    chk("boundary pre control", control, 8);
    pulse_stop();
    chk_idle("boundary stop");

    // Write and start while busy are ignored; abort at T0+100
    pulse_start(3, 1'b1);
    repeat (49) tick();
    wr(0, 77, 5);
    num_steps = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy start cfg_err", cfg_err, 0);
    chk("busy start control", control, -3);
    chk("busy start busy", busy, 1);
    repeat (48) tick();
    chk("abort pre control", control, -3);
    pulse_stop();
    chk_idle("abort");

    // Re-run shows entry 0 kept {8,40}
    pulse_start(3, 1'b0);
    chk("rerun k1 control", control, 8);
    chk("rerun k1 strobe", step_strobe, 1);
    repeat (39) tick();
    chk("rerun k40 control", control, 8);
    tick();
    chk("rerun k41 control", control, -3);
    chk("rerun k41 strobe", step_strobe, 1);
    pulse_stop();
    chk_idle("rerun stop");

    // Write accepted once idle; single entry {5,0} looping
    wr(0, 5, 0);
    pulse_start(1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("single control k=%0d", k), control, 5);
      chk($sformatf("single strobe k=%0d", k), step_strobe, 1);
      chk($sformatf("single idx k=%0d", k), step_idx, 0);
      chk($sformatf("single done k=%0d", k), done, 0);
      tick();
    end
    pulse_stop();
    chk_idle("single stop");

    // Rejected starts
    pulse_start(0, 1'b0);
    chk("num0 cfg_err", cfg_err, 1);
    chk("num0 busy", busy, 0);
    tick();
    chk("num0 cfg_err clears", cfg_err, 0);
    pulse_start(9, 1'b0);
    chk("num9 cfg_err", cfg_err, 1);
    chk("num9 busy", busy, 0);
    tick();

    // num_steps == DEPTH is accepted
    pulse_start(8, 1'b0);
    chk("num8 busy", busy, 1);
    chk("num8 cfg_err", cfg_err, 0);
    chk("num8 control", control, 5);
    pulse_stop();
    chk_idle("num8 stop");

    // start and stop together from IDLE
    num_steps = 4'd3;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk_idle("start+stop");
    chk("start+stop cfg_err", cfg_err, 0);
    num_steps = 4'd0;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("start+stop num0 cfg_err", cfg_err, 0);

    // Async reset mid-dwell
    wr(0, 8, 40);
    pulse_start(3, 1'b0);
    repeat (50) tick();
    chk("prereset control", control, -3);
    chk("prereset idx", step_idx, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset control", control, 0);
    chk("async reset busy", busy, 0);
    chk("async reset idx", step_idx, 0);
    #2;
    reset = 1'b0;
    tick();

    // Cleared table: every entry is {0,0}, so each step lasts one cycle
    pulse_start(3, 1'b0);
    chk("cleared k1 control", control, 0);
    chk("cleared k1 strobe", step_strobe, 1);
    chk("cleared k1 busy", busy, 1);
    chk("cleared k1 idx", step_idx, 0);
    tick();
    chk("cleared k2 idx", step_idx, 1);
    chk("cleared k2 strobe", step_strobe, 1);
    tick();
    chk("cleared k3 idx", step_idx, 2);
    chk("cleared k3 control", control, 0);
    tick();
    chk("cleared k4 done", done, 1);
    chk("cleared k4 busy", busy, 0);
    tick();
    chk("cleared k5 done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/waveform_hop_scheduler.md
Name: waveform_hop_scheduler

Overview:
Frequency-hop sequencer for the waveform generator.
- Holds a small programmable table of (control, dwell) entries.
- Steps through the table and drives the generator's signed phase-step `control` input for each entry's dwell time.
- Supports one-shot and looping sequences.
- Replaces the fixed period-to-control controller when multi-tone test sequences are needed.

Parameters:
- DEPTH, 8, number of table entries; power of two, 2..16.
- CTRL_W, 9, width of signed control word to the waveform generator.
- DWELL_W, 16, width of per-entry dwell count, in clk cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(DEPTH)  table write address.
- cfg_control  in  CTRL_W signed  control value for the entry.
- cfg_dwell  in  DWELL_W  dwell cycles for the entry.
- num_steps  in  $clog2(DEPTH)+1  sequence length, sampled at start.
- loop_en  in  1  1 = wrap to entry 0 after last step; sampled at start.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle abort pulse.
- control  out  CTRL_W signed  registered control word to the waveform generator.
- busy  out  1  high while a sequence runs.
- step_idx  out  $clog2(DEPTH)  index of the entry currently applied.
- step_strobe  out  1  one-cycle pulse in the first cycle a new entry's control is output.
- done  out  1  one-cycle pulse on natural completion of a non-looping sequence.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high; ports are named clk and reset.
- Reset values:
  - control=0, busy=0, step_idx=0, step_strobe=0, done=0, cfg_err=0.
  - State = IDLE; all table entries cleared to control=0, dwell=0.
- States: IDLE and RUN.
- Table writes:
  - A write happens on the clk edge when cfg_we=1 and busy=0.
  - cfg_we while busy=1 is ignored; the table is frozen during RUN.
- IDLE -> RUN:
  - Condition: start=1, stop=0, 1 <= num_steps <= DEPTH.
  - Next cycle: busy=1, step_idx=0, control=table[0].control, step_strobe=1.
  - Dwell counter loads max(table[0].dwell, 1).
  - num_steps and loop_en are latched at this edge.
- start rejection in IDLE:
  - num_steps=0 or num_steps>DEPTH: start ignored, cfg_err=1 for one cycle, state stays IDLE.
  - start while in RUN: ignored, no cfg_err.
- Dwell:
  - Each entry drives control for exactly max(dwell,1) cycles; dwell=0 is treated as 1.
  - control changes only at step boundaries and is registered (no combinational path from inputs).
- Step boundary (counter expires):
  - Not last step: step_idx+1, load next entry, step_strobe=1.
  - Last step with loop_en latched=1: step_idx wraps to 0, load entry 0, step_strobe=1, no done.
  - Last step with loop_en latched=0: next cycle IDLE, control=0, busy=0, step_idx=0, done=1.
- stop:
  - stop=1 in RUN: next cycle IDLE, control=0, busy=0, step_idx=0; no done, no step_strobe.
  - stop wins over a simultaneous step boundary.
  - stop=1 in IDLE: no effect; start in the same cycle is ignored and cfg_err stays 0.
- Single-entry sequence (num_steps=1):
  - loop_en=1: step_strobe pulses every max(dwell,1) cycles; control is constant.
- Reset mid-RUN: immediate return to reset values; table contents are lost.
- Widths:
  - Dwell counter is DWELL_W bits, unsigned.
  - step_idx compare is against latched num_steps-1.
  - No arithmetic on control; passes through unmodified, sign preserved.

Decomposition:
- Package waveform_pkg holds:
  - Constants CTRL_W and DWELL_W.
  - typedef hop_entry_t {signed [CTRL_W-1:0] control; [DWELL_W-1:0] dwell}.
  - typedef hop_state_t enum {IDLE, RUN}.
- One sub-module, waveform_hop_table: DEPTH x hop_entry_t register file with async clear, one write port and one combinational read port.
- The FSM, dwell counter and output registers stay in waveform_hop_scheduler.

Test Plan:
- One-shot sequence:
  - Program table = {8,40}, {-3,100}, {1,250}; num_steps=3, loop_en=0; pulse start at edge T0.
  - control=8 for cycles T0+1..T0+40, -3 for T0+41..T0+140, 1 for T0+141..T0+390.
  - At T0+391: control=0, busy=0, done=1 for one cycle; step_strobe at T0+1, T0+41, T0+141 only.
- Looping sequence:
  - Same table, loop_en=1, run 800 cycles.
  - control returns to 8 at T0+391 with step_strobe=1, step_idx=0; done never asserts.
- Abort:
  - Looping run; stop at T0+100.
  - From T0+101: control=0, busy=0, no done; cfg_we now accepted.
- Edge cases:
  - Entry {5,0}, num_steps=1, loop_en=1: step_strobe every cycle, control=5.
  - num_steps=0: start gives cfg_err=1 for one cycle, busy stays 0.
  - start and stop in the same cycle from IDLE: nothing happens.
- Simultaneous events:
  - stop coincident with a step boundary: returns to IDLE, no step_strobe.
  - cfg_we to entry 0 while busy: table unchanged, verified by re-running the sequence.
- Async reset:
  - Assert reset mid-dwell, between clk edges.
  - Outputs are 0 immediately, before the next edge; after release, a start with the same num_steps outputs control=0 (table cleared).
